// File: rtl/serial_alu_seq_if.sv
// rtl/serial_alu_seq_if.sv - request/response bus between the operand source and serial_alu_seq
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode_in;
    logic [1:0]       op_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_out;
    logic             cout_out;
    logic             zero_out;

    modport master (
        output start, mode_in, op_in, a_in, b_in, cin_in,
        input  busy, done, result_out, cout_out, zero_out
    );

    modport slave (
        input  start, mode_in, op_in, a_in, b_in, cin_in,
        output busy, done, result_out, cout_out, zero_out
    );
endinterface

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial sequencer feeding a 1-bit ALU slice and mode_mux stage
module serial_alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_alu_seq_if.slave    bus,
    output logic               slice_a,
    output logic               slice_b,
    output logic               slice_cin,
    output logic [1:0]         slice_op,
    output logic               mode_mux,
    input  logic               result_final,
    input  logic               Cout_final
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             carry_reg;
    logic [CNT_W-1:0] idx;
    logic [1:0]       op_l;
    logic             mode_l;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             zero_r;
    logic             accept;

    // New requests are taken from IDLE and from DONE, giving back-to-back operation.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign r_next = {result_final, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            op_l      <= 2'b00;
            mode_l    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            cout_r    <= 1'b0;
            zero_r    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        state  <= SHIFT;
                        busy_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sh      <= r_next;
                    carry_reg <= Cout_final;
                    idx       <= idx + CNT_W'(1);
                    if (idx == LAST_IDX) begin
                        result_r <= r_next;
                        cout_r   <= Cout_final;
                        zero_r   <= (r_next == '0);
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        // Operands stop shifting on the last bit so slice_a/b hold their final values.
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        state  <= SHIFT;
                        busy_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase

            if (accept) begin
                a_sh      <= bus.a_in;
                b_sh      <= bus.b_in;
                op_l      <= bus.op_in;
                mode_l    <= bus.mode_in;
                carry_reg <= bus.cin_in;
                idx       <= '0;
                r_sh      <= '0;
            end
        end
    end

    assign slice_a        = a_sh[0];
    assign slice_b        = b_sh[0];
    assign slice_cin      = carry_reg;
    assign slice_op       = op_l;
    assign mode_mux       = mode_l;

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result_out = result_r;
    assign bus.cout_out   = cout_r;
    assign bus.zero_out   = zero_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - directed self-checking bench for serial_alu_seq
module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    logic       clk;
    logic       rst_n;
    logic       slice_a;
    logic       slice_b;
    logic       slice_cin;
    logic [1:0] slice_op;
    logic       mode_mux;
    logic       result_final;
    logic       Cout_final;

    int errors;
    int checks;
    int cyc;
    int cin_ok;
    int mode_ok;

    serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .mode_mux     (mode_mux),
        .result_final (result_final),
        .Cout_final   (Cout_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: arith op 00 = full adder, logic op 00 = AND; other ops = XOR.
    always_comb begin
        result_final = 1'b0;
        Cout_final   = 1'b0;
        if (!mode_mux) begin
            if (slice_op == 2'b00) begin
                result_final = slice_a ^ slice_b ^ slice_cin;
                Cout_final   = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
            end else begin
                result_final = slice_a ^ slice_b;
            end
        end else begin
            if (slice_op == 2'b00) result_final = slice_a & slice_b;
            else                   result_final = slice_a ^ slice_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic mode, input logic [1:0] op);
        bus.a_in    = a;
        bus.b_in    = b;
        bus.cin_in  = cin;
        bus.mode_in = mode;
        bus.op_in   = op;
        bus.start   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Cycle c runs between start edge E(c-1) and E(c); samples taken on the falling edge.
    task automatic wait_done(input int c0, output int c_done);
        c_done  = -1;
        cin_ok  = 1;
        mode_ok = 1;
        for (int c = c0; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                if (mode_mux !== bus.mode_in) mode_ok = 0;
                if (c >= 2 && c <= 8 && slice_cin !== 1'b1) cin_ok = 0;
            end
            if (bus.done) begin
                c_done = c;
                break;
            end
        end
        if (c_done < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.cin_in   = 1'b0;
        bus.mode_in  = 1'b0;
        bus.op_in    = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, bus.busy},     32'd0);
        check("rst_done",   {31'd0, bus.done},     32'd0);
        check("rst_result", {24'd0, bus.result_out}, 32'd0);
        check("rst_cout",   {31'd0, bus.cout_out}, 32'd0);
        check("rst_zero",   {31'd0, bus.zero_out}, 32'd1);
        check("rst_mode",   {31'd0, mode_mux},     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic add
        issue(8'h5A, 8'h33, 1'b0, 1'b0, 2'b00);
        wait_done(1, cyc);
        check("add_cycle",  cyc, 32'd9);
        check("add_result", {24'd0, bus.result_out}, 32'h8D);
        check("add_cout",   {31'd0, bus.cout_out}, 32'd0);
        check("add_zero",   {31'd0, bus.zero_out}, 32'd0);
        check("add_busy",   {31'd0, bus.busy},     32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, bus.done},     32'd0);

        // Carry out with zero result
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 2'b00);
        wait_done(1, cyc);
        check("ff_result", {24'd0, bus.result_out}, 32'h00);
        check("ff_cout",   {31'd0, bus.cout_out}, 32'd1);
        check("ff_zero",   {31'd0, bus.zero_out}, 32'd1);
        check("ff_cin_chain", cin_ok, 32'd1);
        @(negedge clk);

        // Logic AND
        issue(8'hF0, 8'h3C, 1'b0, 1'b1, 2'b00);
        wait_done(1, cyc);
        check("and_result", {24'd0, bus.result_out}, 32'h30);
        check("and_cout",   {31'd0, bus.cout_out}, 32'd0);
        check("and_zero",   {31'd0, bus.zero_out}, 32'd0);
        check("and_mode",   mode_ok, 32'd1);
        @(negedge clk);

        // Carry-in propagation
        issue(8'h00, 8'h00, 1'b1, 1'b0, 2'b00);
        wait_done(1, cyc);
        check("cin_result", {24'd0, bus.result_out}, 32'h01);
        check("cin_cout",   {31'd0, bus.cout_out}, 32'd0);
        check("cin_zero",   {31'd0, bus.zero_out}, 32'd0);
        @(negedge clk);

        // Start during SHIFT is ignored, operand changes have no effect
        issue(8'h5A, 8'h33, 1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        bus.a_in    = 8'hFF;
        bus.b_in    = 8'hFF;
        bus.mode_in = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mode_in = 1'b0;
        check("busy_hold_result", {24'd0, bus.result_out}, 32'h01);
        wait_done(5, cyc);
        check("ign_cycle",  cyc, 32'd9);
        check("ign_result", {24'd0, bus.result_out}, 32'h8D);

        // Start in the DONE cycle: back-to-back
        bus.a_in   = 8'h01;
        bus.b_in   = 8'h02;
        bus.cin_in = 1'b0;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_done", {31'd0, bus.done}, 32'd0);
        check("b2b_hold", {24'd0, bus.result_out}, 32'h8D);
        wait_done(2, cyc);
        check("b2b_cycle",  cyc, 32'd9);
        check("b2b_result", {24'd0, bus.result_out}, 32'h03);
        @(negedge clk);

        // Asynchronous reset mid-operation
        issue(8'h12, 8'h34, 1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   {31'd0, bus.busy},       32'd0);
        check("arst_done",   {31'd0, bus.done},       32'd0);
        check("arst_result", {24'd0, bus.result_out}, 32'h00);
        check("arst_zero",   {31'd0, bus.zero_out},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_done", {31'd0, bus.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial sequencer that drives the 1-bit ALU slice and the mode_mux selection stage, and consumes their outputs (result_final, Cout_final).
- Feeds one operand bit per cycle and chains the carry through a register.
- Assembles the WIDTH-bit result and reports carry and zero through a start/busy/done handshake.
- Sits between the register-file/operand source and the combinational slice path.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- mode_in  in  1  0=arithmetic, 1=logic; latched at start.
- op_in  in  2  slice opcode; latched at start.
- a_in  in  WIDTH  operand A; latched at start.
- b_in  in  WIDTH  operand B; latched at start.
- cin_in  in  1  carry-in for bit 0; latched at start.
- slice_a  out  1  current A bit to slice.
- slice_b  out  1  current B bit to slice.
- slice_cin  out  1  carry into slice for current bit.
- slice_op  out  2  latched opcode to slice.
- mode_mux  out  1  latched mode; drives mode_mux select.
- result_final  in  1  selected result bit from mode_mux (combinational from slice_*).
- Cout_final  in  1  selected carry from mode_mux.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result_out, cout_out and zero_out update.
- result_out  out  WIDTH  assembled result; held until the next completion.
- cout_out  out  1  Cout_final of bit WIDTH-1.
- zero_out  out  1  1 when result_out == 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy=0, done=0, result_out=0, cout_out=0, zero_out=1. All slice_* outputs, mode_mux and internal registers are 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch a_in, b_in, op_in, mode_in and cin_in into shift/holding registers. Set carry_reg=cin_in and idx=0, then go to SHIFT. With start=0, stay in IDLE.
- SHIFT (busy=1):
  - slice_a=A_sh[0], slice_b=B_sh[0], slice_cin=carry_reg, slice_op=op_l, mode_mux=mode_l.
  - At each rising edge: shift result_final into the MSB of R_sh (right-shift, so bit 0 lands in R_sh[0] after WIDTH shifts). Shift A_sh and B_sh right, set carry_reg=Cout_final, and increment idx.
  - When idx==WIDTH-1 at the edge: load result_out from the final R_sh value including this bit, set cout_out=Cout_final, compute zero_out from the same value, and go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and the next state is SHIFT.
- Latency: start sampled at edge E0. The slice sees bit k during cycle k+1 (between edges Ek and Ek+1). done is high in the cycle after edge E_WIDTH, which is WIDTH+1 cycles after the start edge.
- start while busy=1 is ignored; latched operands and mode do not change mid-operation.
- Carry chain is identical in both modes. In logic mode the chain carries whatever Cout_final the logic path returns.
- result_out, cout_out and zero_out change only at completion. They hold their values through IDLE and through subsequent SHIFT phases.
- Outside SHIFT, the slice_* outputs and mode_mux hold their last values. slice_cin outside SHIFT is don't-care.
- Reset asserted mid-SHIFT: immediate return to the reset values. No done pulse and no partial result.
- Input changes on a_in/b_in during SHIFT have no effect.

Test Plan:
- The bench slice model implements arith op 00 as a full adder and logic op 00 as AND (Cout=0). WIDTH=8 throughout.
- Reset check: drive rst_n=0 mid-operation -> busy=0, done=0, result_out=0x00, zero_out=1 without waiting for a clock edge.
- Arith add: a=0x5A, b=0x33, cin=0, mode=0, op=00 -> done 9 cycles after the start edge, result_out=0x8D, cout_out=0, zero_out=0.
- Carry out/zero: a=0xFF, b=0x01, cin=0, arith -> result_out=0x00, cout_out=1, zero_out=1. Also verify slice_cin=1 on bits 1..7.
- Logic AND: a=0xF0, b=0x3C, mode=1 -> result_out=0x30, cout_out=0. Verify mode_mux=1 throughout SHIFT.
- Handshake: pulse start during SHIFT with different operands -> ignored, and the first result is unchanged. Assert start during the DONE cycle -> the second operation begins, with busy high on the next cycle and no IDLE cycle.
- cin propagation: a=0x00, b=0x00, cin=1, arith -> result_out=0x01, cout_out=0, zero_out=0.
